// File: rtl/multi_key_interrupt_controller_if.sv
// Bus between the interrupt controller and the CPU / key front end.
//   keys, key_mask        : raw key levels (1 = pressed) and per-key enables
//   interrupt_ack         : CPU accepts the instruction currently offered
//   interrupt_valid       : an interrupt instruction is being offered
//   interrupt_instruction : {opcode, source_id, 22'b0}, zero when not valid
//   frame_overrun         : sticky flag, a frame tick was lost
//   overrun_count         : saturating count of lost frame ticks
// master = CPU/key side, slave = controller.
interface multi_key_interrupt_controller_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] keys;
  logic [N_KEYS-1:0] key_mask;
  logic              interrupt_ack;
  logic              interrupt_valid;
  logic [31:0]       interrupt_instruction;
  logic              frame_overrun;
  logic [7:0]        overrun_count;

  modport master (
    output keys, key_mask, interrupt_ack,
    input  interrupt_valid, interrupt_instruction, frame_overrun, overrun_count
  );

  modport slave (
    input  keys, key_mask, interrupt_ack,
    output interrupt_valid, interrupt_instruction, frame_overrun, overrun_count
  );
endinterface

// File: rtl/multi_key_interrupt_controller.sv
// Multi-key interrupt controller.
// Merges a periodic frame tick and N_KEYS key inputs into pending sources and
// offers one interrupt instruction at a time to the CPU with a valid/ack
// handshake. Source 0 = frame (lowest priority), source k+1 = key k (key 0
// highest).
// Ports:
//   proc_clk : sole clock, rising edge
//   reset    : synchronous, active high
//   bus      : slave side of multi_key_interrupt_controller_if
module multi_key_interrupt_controller #(
  parameter int          N_KEYS     = 4,
  parameter int          FRAME_DIV  = 833333,
  parameter int          KEY_MODE   = 1,
  parameter logic [4:0]  INT_OPCODE = 5'b11111
) (
  input  logic proc_clk,
  input  logic reset,
  multi_key_interrupt_controller_if.slave bus
);
  localparam int CW = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state;
  logic [CW-1:0]     frame_cnt;
  logic              frame_tick;
  logic [N_KEYS-1:0] key_s1, key_s2, key_hist;
  logic [1:0]        warm;
  logic [N_KEYS-1:0] key_evt, key_pending, key_clr;
  logic              frame_pending, frame_clr, ack_take, any_pending;
  logic [4:0]        sel_id, grant_id;
  logic              valid_q, overrun_q;
  logic [31:0]       instr_q;
  logic [7:0]        ovr_cnt;

  assign frame_tick = (frame_cnt == CW'(FRAME_DIV - 1));

  // Frame divider.
  always_ff @(posedge proc_clk) begin
    if (reset)           frame_cnt <= '0;
    else if (frame_tick) frame_cnt <= '0;
    else                 frame_cnt <= frame_cnt + CW'(1);
  end

  // Two-flop synchronizer plus edge history. For the first two cycles after
  // reset the history follows the value about to land in key_s2, so a key
  // held through reset release looks like an old level, not a new press.
  always_ff @(posedge proc_clk) begin
    if (reset) begin
      key_s1   <= '0;
      key_s2   <= '0;
      key_hist <= '0;
      warm     <= '0;
    end else begin
      key_s1   <= bus.keys;
      key_s2   <= key_s1;
      key_hist <= (warm == 2'd2) ? key_s2 : key_s1;
      if (warm != 2'd2) warm <= warm + 2'd1;
    end
  end

  always_comb begin
    key_evt = '0;
    if (KEY_MODE == 1) begin
      if (warm == 2'd2) key_evt = key_s2 & ~key_hist & bus.key_mask;
    end else if (frame_tick) begin
      key_evt = key_s2 & bus.key_mask;
    end
  end

  // Clear requests for the granted source; a same-cycle event wins.
  assign ack_take  = (state == ISSUE) && bus.interrupt_ack;
  assign frame_clr = ack_take && (grant_id == 5'd0);

  always_comb begin
    for (int k = 0; k < N_KEYS; k++)
      key_clr[k] = ack_take && (grant_id == 5'(k + 1));
  end

  always_ff @(posedge proc_clk) begin
    if (reset) begin
      key_pending   <= '0;
      frame_pending <= 1'b0;
      overrun_q     <= 1'b0;
      ovr_cnt       <= '0;
    end else begin
      key_pending   <= (key_pending & ~key_clr) | key_evt;
      frame_pending <= (frame_pending & ~frame_clr) | frame_tick;
      if (frame_tick && frame_pending && !frame_clr) begin
        overrun_q <= 1'b1;
        if (ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
      end
    end
  end

  // Priority select: lowest pending key index wins, frame only if no key.
  always_comb begin
    sel_id      = 5'd0;
    any_pending = frame_pending | (|key_pending);
    for (int k = N_KEYS - 1; k >= 0; k--)
      if (key_pending[k]) sel_id = 5'(k + 1);
  end

  // Grant FSM. Selection happens only in IDLE, so arrivals during ISSUE
  // wait for the next IDLE cycle.
  always_ff @(posedge proc_clk) begin
    if (reset) begin
      state    <= IDLE;
      grant_id <= '0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
    end else begin
      case (state)
        IDLE: if (any_pending) begin
          state    <= ISSUE;
          grant_id <= sel_id;
          valid_q  <= 1'b1;
          instr_q  <= {INT_OPCODE, sel_id, 22'b0};
        end
        ISSUE: if (bus.interrupt_ack) begin
          state    <= IDLE;
          valid_q  <= 1'b0;
          instr_q  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.interrupt_valid       = valid_q;
  assign bus.interrupt_instruction = instr_q;
  assign bus.frame_overrun         = overrun_q;
  assign bus.overrun_count         = ovr_cnt;
endmodule

// File: doc/multi_key_interrupt_controller.md
MULTI_KEY_INTERRUPT_CONTROLLER -- requirements
Module: multi_key_interrupt_controller

Interface
REQ-001 The block SHALL have parameter N_KEYS, default 4, number of key inputs (1..30).
REQ-002 The block SHALL have parameter FRAME_DIV, default 833333, proc_clk cycles per frame tick (50 MHz / 60 fps; >= 2).
REQ-003 The block SHALL have parameter KEY_MODE, default 1: 0 = key sampled at frame tick (level), 1 = key rising edge captured any cycle.
REQ-004 The block SHALL have parameter INT_OPCODE, default 5'b11111, opcode placed in interrupt instructions.
REQ-005 proc_clk  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 keys  input  N_KEYS  raw asynchronous key levels, 1 = pressed.
REQ-008 key_mask  input  N_KEYS  1 = key enabled; masked keys never set pending.
REQ-009 interrupt_ack  input  1  CPU accepts current instruction.
REQ-010 interrupt_valid  output  1  instruction pending for CPU.
REQ-011 interrupt_instruction  output  32  instruction; 32'b0 whenever interrupt_valid = 0.
REQ-012 frame_overrun  output  1  sticky: frame tick lost.
REQ-013 overrun_count  output  8  saturating count of lost frame ticks.

Function
REQ-014 Frame counter SHALL count 0..FRAME_DIV-1 and wrap to 0; frame_tick is an internal 1-cycle pulse in the cycle counter = FRAME_DIV-1.
REQ-015 Each key SHALL pass a 2-flop synchronizer; key event latency from keys to pending = 3 cycles in KEY_MODE 1.
REQ-016 KEY_MODE 1: pending[k] SHALL set on synchronized rising edge of key k when key_mask[k] = 1; held key produces one event only.
REQ-017 KEY_MODE 0: pending[k] SHALL set on frame_tick when synchronized key k = 1 and key_mask[k] = 1.
REQ-018 frame_pending SHALL set on every frame_tick.
REQ-019 Source IDs: 0 = frame, k+1 = key k; priority: key 0 highest, then ascending key index, frame lowest.
REQ-020 State machine IDLE/ISSUE: in IDLE, if any source pending, latch highest-priority source ID, go to ISSUE; interrupt_valid = 1 from next cycle.
REQ-021 In ISSUE, interrupt_instruction = {INT_OPCODE, source_id[4:0], 22'b0}, held stable until ack.
REQ-022 interrupt_ack = 1 in ISSUE SHALL clear the granted source's pending bit and return to IDLE; interrupt_valid = 0 next cycle.
REQ-023 Minimum one IDLE cycle between consecutive grants; back-to-back pending sources issue in priority order.
REQ-024 interrupt_ack in IDLE SHALL be ignored.
REQ-025 New event for the granted source in the ack cycle SHALL leave that pending bit set (set wins over clear).
REQ-026 Key events to an already-pending key SHALL merge silently (no overrun).
REQ-027 frame_tick while frame_pending = 1 (and not cleared that cycle) SHALL set frame_overrun and increment overrun_count, saturating at 255.
REQ-028 Pending bits SHALL not be re-prioritised while in ISSUE; a higher-priority arrival waits for next IDLE.
REQ-029 Clearing key_mask[k] SHALL not clear an already-set pending[k].

Reset
REQ-030 reset = 1 at a rising edge SHALL clear counter, synchronizers, edge history, all pending bits, state to IDLE, interrupt_valid = 0, interrupt_instruction = 0, frame_overrun = 0, overrun_count = 0.
REQ-031 Reset mid-ISSUE SHALL abandon the grant; no ack required afterward.
REQ-032 First frame_tick after reset release SHALL occur FRAME_DIV cycles after the release edge.
REQ-033 Keys held through reset release SHALL not generate a KEY_MODE 1 event (edge history resets to 1-synchronized level after 2 cycles, not 0).

Verification
REQ-034 FRAME_DIV=10, no keys, ack 1 cycle after valid -> valid every 10 cycles, instruction = 32'hF8000000.
REQ-035 KEY_MODE 1, key 2 pulse, mask all 1 -> valid within 4 cycles, instruction = 32'hF8C00000; hold key 50 cycles -> single event.
REQ-036 Keys 0 and 3 pressed same cycle with frame pending -> grants in order ID 1, 4, 0 after successive acks, one IDLE cycle between each.
REQ-037 No ack for 35 cycles, FRAME_DIV=10 -> frame_overrun = 1, overrun_count = 2; after 300 missed ticks count = 255.
REQ-038 Reset asserted during ISSUE -> next cycle valid = 0, instruction = 0, overrun_count = 0; key masked (key_mask[1]=0) press -> no interrupt.
